redun_carry_resolve: RTL and testbench

- Sits directly downstream of the redundant-form Montgomery multiplier.
- Accepts one result in redundant form: NUM_WRDS words, each WRD_BITS+1 bits wide, holding a 16-bit digit plus a carry bit.
- Resolves carries sequentially, two redundant words per output beat, and streams the plain binary value to the msu interface as AXI_LEN-bit beats.
- Flags any carry out of bit DAT_BITS.

---
 rtl/redun_mont_pkg.sv | 59 +++++
 rtl/redun_beat_adder.sv | 26 ++
 rtl/redun_carry_resolve.sv | 123 ++++++++++++
 tb/tb_redun_carry_resolve.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/redun_mont_pkg.sv
// Shared types and helpers for the redundant-form Montgomery datapath.
package redun_mont_pkg;

    localparam int unsigned NUM_WRDS  = 65;
    localparam int unsigned WRD_BITS  = 16;
    localparam int unsigned AXI_LEN   = 32;
    localparam int unsigned DAT_BITS  = NUM_WRDS * WRD_BITS;

    // Beats per resolved result; fixed by the word geometry.
    localparam int unsigned NUM_BEATS = (NUM_WRDS * WRD_BITS + AXI_LEN - 1) / AXI_LEN;
    localparam int unsigned BEAT_W    = $clog2(NUM_BEATS);
    // Word index must reach one past the last pair of the final beat.
    localparam int unsigned IDX_W     = BEAT_W + 1;
    localparam int unsigned SUM_W     = WRD_BITS + 2;

    // One redundant word: 16-bit digit plus a carry bit.
    typedef logic [WRD_BITS:0] redun_wrd_t;
    typedef redun_wrd_t [NUM_WRDS-1:0] redun0_t;

    typedef struct packed {
        logic [1:0]         carry;
        logic [AXI_LEN-1:0] beat;
    } beat_res_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rcr_state_t;

    // Resolve two adjacent redundant words with an incoming carry.
    function automatic beat_res_t resolve_beat(
        input redun_wrd_t word_lo,
        input redun_wrd_t word_hi,
        input logic [1:0] carry_in
    );
        logic [SUM_W-1:0] s0;
        logic [SUM_W-1:0] s1;
        beat_res_t        res;
        s0        = SUM_W'(word_lo) + SUM_W'(carry_in);
        s1        = SUM_W'(word_hi) + SUM_W'(s0[SUM_W-1:WRD_BITS]);
        res.beat  = {s1[WRD_BITS-1:0], s0[WRD_BITS-1:0]};
        res.carry = s1[SUM_W-1:WRD_BITS];
        return res;
    endfunction

    // Bounds-checked word fetch; indices past the array read as zero.
    function automatic redun_wrd_t wrd_at(
        input redun0_t          w,
        input logic [IDX_W-1:0] idx
    );
        redun_wrd_t r;
        r = '0;
        if (32'(idx) < NUM_WRDS) begin
            r = w[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/redun_beat_adder.sv
// Combinational two-word carry resolve producing one output beat.
module redun_beat_adder
    import redun_mont_pkg::*;
(
    input  redun_wrd_t         word_lo,
    input  redun_wrd_t         word_hi,
    input  logic               hi_vld,
    input  logic [1:0]         carry_in,
    output logic [AXI_LEN-1:0] beat_c,
    output logic [1:0]         carry_c
);

    beat_res_t res_c;

    // With no upper word, the carry out of the low word leaves the beat instead of filling its top half.
    always_comb begin
        res_c   = resolve_beat(word_lo, hi_vld ? word_hi : '0, carry_in);
        beat_c  = res_c.beat;
        carry_c = res_c.carry;
        if (!hi_vld) begin
            beat_c  = AXI_LEN'(res_c.beat[WRD_BITS-1:0]);
            carry_c = res_c.beat[WRD_BITS +: 2];
        end
    end

endmodule

// File: rtl/redun_carry_resolve.sv
// Resolves a redundant-form result into binary beats, least-significant first.
module redun_carry_resolve
    import redun_mont_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  redun0_t            i_dat,
    input  logic               i_val,
    output logic               o_rdy,
    output logic [AXI_LEN-1:0] o_dat,
    output logic               o_val,
    input  logic               i_rdy,
    output logic               o_last,
    output logic               o_ovf
);

    rcr_state_t        state;
    redun0_t           words;
    logic [1:0]        carry;
    logic [BEAT_W-1:0] beat;

    logic [BEAT_W-1:0]  nxt_beat_c;
    logic [IDX_W-1:0]   idx_lo_c;
    logic [IDX_W-1:0]   idx_hi_c;
    redun0_t            src_c;
    redun_wrd_t         lo_c;
    redun_wrd_t         hi_c;
    logic               hi_vld_c;
    logic [1:0]         cin_c;
    logic               nxt_last_c;
    logic [AXI_LEN-1:0] add_beat_c;
    logic [1:0]         add_carry_c;
    logic               take_c;
    logic               give_c;

    // Select operands for the beat that will be presented next.
    always_comb begin
        nxt_beat_c = '0;
        src_c      = i_dat;
        cin_c      = 2'b00;
        if (state == STREAM) begin
            nxt_beat_c = beat + BEAT_W'(1);
            src_c      = words;
            cin_c      = carry;
        end
        idx_lo_c   = IDX_W'({nxt_beat_c, 1'b0});
        idx_hi_c   = idx_lo_c | IDX_W'(1);
        lo_c       = wrd_at(src_c, idx_lo_c);
        hi_c       = wrd_at(src_c, idx_hi_c);
        hi_vld_c   = (32'(idx_hi_c) < NUM_WRDS);
        nxt_last_c = (nxt_beat_c == BEAT_W'(NUM_BEATS - 1));
        take_c     = (state == IDLE) && i_val && o_rdy;
        give_c     = (state == STREAM) && o_val && i_rdy;
    end

    redun_beat_adder u_adder (
        .word_lo  (lo_c),
        .word_hi  (hi_c),
        .hi_vld   (hi_vld_c),
        .carry_in (cin_c),
        .beat_c   (add_beat_c),
        .carry_c  (add_carry_c)
    );

    // Capture, stream and handshake control with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            words  <= '0;
            carry  <= 2'b00;
            beat   <= '0;
            o_rdy  <= 1'b1;
            o_val  <= 1'b0;
            o_last <= 1'b0;
            o_ovf  <= 1'b0;
            o_dat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_rdy <= 1'b1;
                    o_val <= 1'b0;
                    if (take_c) begin
                        words  <= i_dat;
                        o_dat  <= add_beat_c;
                        carry  <= add_carry_c;
                        beat   <= nxt_beat_c;
                        o_last <= nxt_last_c;
                        o_ovf  <= nxt_last_c && (add_carry_c != 2'b00);
                        o_val  <= 1'b1;
                        o_rdy  <= 1'b0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    o_rdy <= 1'b0;
                    if (give_c) begin
                        if (beat == BEAT_W'(NUM_BEATS - 1)) begin
                            o_val  <= 1'b0;
                            o_last <= 1'b0;
                            o_ovf  <= 1'b0;
                            o_rdy  <= 1'b1;
                            carry  <= 2'b00;
                            beat   <= '0;
                            state  <= IDLE;
                        end else begin
                            o_dat  <= add_beat_c;
                            carry  <= add_carry_c;
                            beat   <= nxt_beat_c;
                            o_last <= nxt_last_c;
                            o_ovf  <= nxt_last_c && (add_carry_c != 2'b00);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    o_rdy <= 1'b1;
                    o_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redun_carry_resolve.sv
// Directed and randomized checks of redun_carry_resolve against an integer-value model.
module tb_redun_carry_resolve;
    import redun_mont_pkg::*;

    localparam int unsigned ACC_W  = DAT_BITS + 8;
    localparam int unsigned FLAT_W = NUM_BEATS * AXI_LEN;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    redun0_t            i_dat;
    logic               i_val;
    logic               o_rdy;
    logic [AXI_LEN-1:0] o_dat;
    logic               o_val;
    logic               i_rdy;
    logic               o_last;
    logic               o_ovf;

    int total = 0;
    int bad   = 0;

    redun_carry_resolve dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_dat   (i_dat),
        .i_val   (i_val),
        .o_rdy   (o_rdy),
        .o_dat   (o_dat),
        .o_val   (o_val),
        .i_rdy   (i_rdy),
        .o_last  (o_last),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    // Integer value held by a redundant result: sum of word[i] * 2^(16*i).
    function automatic logic [ACC_W-1:0] redun_value(input redun0_t r);
        logic [ACC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_WRDS; i++) begin
            acc = acc + (ACC_W'(r[i]) << (WRD_BITS * i));
        end
        return acc;
    endfunction

    function automatic logic [AXI_LEN-1:0] exp_beat(input redun0_t r, input int k);
        logic [ACC_W-1:0]  acc;
        logic [FLAT_W-1:0] flat;
        acc  = redun_value(r);
        flat = '0;
        flat[DAT_BITS-1:0] = acc[DAT_BITS-1:0];
        return flat[k*AXI_LEN +: AXI_LEN];
    endfunction

    function automatic logic exp_ovf(input redun0_t r);
        logic [ACC_W-1:0] acc;
        acc = redun_value(r);
        return |acc[ACC_W-1:DAT_BITS];
    endfunction

    function automatic redun0_t to_redun(input logic [DAT_BITS-1:0] v);
        redun0_t r;
        for (int i = 0; i < NUM_WRDS; i++) begin
            r[i] = {1'b0, v[i*WRD_BITS +: WRD_BITS]};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a result and wait (bounded) for acceptance; called at a negedge.
    task automatic send(input redun0_t r, input bit hold);
        int n;
        n = 0;
        i_dat = r;
        i_val = 1'b1;
        while (!o_rdy && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("send_rdy", 64'(o_rdy), 64'(1));
        @(posedge i_clk);
        #1;
        if (!hold) i_val = 1'b0;
        check("latency_val", 64'(o_val), 64'(1));
    endtask

    // Drain one result with i_rdy asserted pct% of cycles; optional reset at beat abort_at.
    task automatic receive(input redun0_t r, input int pct, input int abort_at);
        int                 k;
        int                 cyc;
        bit                 stall;
        logic [AXI_LEN-1:0] sd;
        logic               sl;
        logic               so;
        k     = 0;
        cyc   = 0;
        stall = 1'b0;
        sd    = '0;
        sl    = 1'b0;
        so    = 1'b0;
        while (k < NUM_BEATS && cyc < 4000) begin
            @(negedge i_clk);
            cyc++;
            if (stall) begin
                check("hold_dat", 64'(o_dat), 64'(sd));
                check("hold_last", 64'(o_last), 64'(sl));
                check("hold_ovf", 64'(o_ovf), 64'(so));
            end
            check("val_hi", 64'(o_val), 64'(1));
            check("rdy_low", 64'(o_rdy), 64'(0));
            if (k == abort_at) begin
                i_rst_n = 1'b0;
                #1;
                check("abort_val", 64'(o_val), 64'(0));
                check("abort_last", 64'(o_last), 64'(0));
                check("abort_ovf", 64'(o_ovf), 64'(0));
                check("abort_dat", 64'(o_dat), 64'(0));
                check("abort_rdy", 64'(o_rdy), 64'(1));
                @(negedge i_clk);
                i_rst_n = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(negedge i_clk);
                    check("abort_no_val", 64'(o_val), 64'(0));
                    check("abort_no_last", 64'(o_last), 64'(0));
                end
                i_rdy = 1'b1;
                return;
            end
            i_rdy = ($urandom_range(99) < pct);
            stall = o_val && !i_rdy;
            sd    = o_dat;
            sl    = o_last;
            so    = o_ovf;
            if (o_val && i_rdy) begin
                check("beat_dat", 64'(o_dat), 64'(exp_beat(r, k)));
                check("beat_last", 64'(o_last), 64'(k == NUM_BEATS - 1));
                if (k == NUM_BEATS - 1) begin
                    check("beat_ovf", 64'(o_ovf), 64'(exp_ovf(r)));
                end
                k++;
            end
        end
        check("stream_done", 64'(k), 64'(NUM_BEATS));
        @(negedge i_clk);
        check("val_drop", 64'(o_val), 64'(0));
        check("rdy_back", 64'(o_rdy), 64'(1));
        i_rdy = 1'b1;
    endtask

    redun0_t               zero_r;
    redun0_t               p_r;
    redun0_t               ch_r;
    redun0_t               ov_r;
    redun0_t               rnd_r;
    logic [DAT_BITS-1:0]   p_val;

    initial begin
        i_rst_n = 1'b0;
        i_val   = 1'b0;
        i_rdy   = 1'b1;
        i_dat   = '0;

        zero_r = '0;
        p_val  = '0;
        for (int i = 0; i < 32; i++) p_val[i*32 +: 32] = $urandom;
        p_val[0]    = 1'b1;
        p_val[1023] = 1'b1;
        p_r    = to_redun(p_val);
        ch_r   = '0;
        ch_r[0] = 17'h1FFFF;
        ch_r[1] = 17'h0FFFF;
        ov_r   = '0;
        ov_r[64] = 17'h10000;

        repeat (2) @(negedge i_clk);
        check("rst_rdy", 64'(o_rdy), 64'(1));
        check("rst_val", 64'(o_val), 64'(0));
        check("rst_last", 64'(o_last), 64'(0));
        check("rst_ovf", 64'(o_ovf), 64'(0));
        check("rst_dat", 64'(o_dat), 64'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rdy_after_rst", 64'(o_rdy), 64'(1));
        check("val_after_rst", 64'(o_val), 64'(0));

        // All-zero result, continuous ready
        send(zero_r, 1'b0);
        receive(zero_r, 100, -1);

        // Plain binary P passes through unchanged
        send(p_r, 1'b0);
        receive(p_r, 100, -1);

        // Carry ripple across a word boundary
        send(ch_r, 1'b0);
        receive(ch_r, 100, -1);

        // Carry out of the top word raises overflow on the last beat
        send(ov_r, 1'b0);
        receive(ov_r, 100, -1);

        // Backpressure with a second result held pending during the stream
        send(ch_r, 1'b1);
        i_dat = p_r;
        receive(ch_r, 50, -1);
        @(posedge i_clk);
        #1;
        i_val = 1'b0;
        check("pend_accept", 64'(o_val), 64'(1));
        receive(p_r, 50, -1);

        // Reset during beat 10, then a full clean result
        send(ch_r, 1'b0);
        receive(ch_r, 100, 10);
        send(p_r, 1'b0);
        receive(p_r, 100, -1);

        // Random redundant words, including carry bits and the top word
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NUM_WRDS; i++) rnd_r[i] = 17'($urandom);
            send(rnd_r, 1'b0);
            receive(rnd_r, 30 + 20 * t, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
